// File: rtl/mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mod_addsub_pipe
// Description : LANES-wide 2-stage modular add/sub/neg/pass unit with
//               valid/ready flow control. Optional per-lane operand range
//               checking is enabled by defining MOD_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_addsub_pipe #(
    parameter int              WIDTH = 32,
    parameter longint unsigned MOD   = 998244353,
    parameter int              LANES = 4,
    parameter int              TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_res,
    output logic [TAG_W-1:0]       out_tag,
    output logic [LANES-1:0]       out_err,
    output logic [15:0]            xfer_cnt
);

    localparam logic [1:0]       c_OP_ADD  = 2'b00;
    localparam logic [1:0]       c_OP_SUB  = 2'b01;
    localparam logic [1:0]       c_OP_NEG  = 2'b10;
    localparam logic [WIDTH:0]   c_MOD     = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] c_MOD_W   = WIDTH'(MOD);

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_in_xfer;
    logic             w_s2_adv;
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [1:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic [TAG_W-1:0] r_s2_tag;
    logic [15:0]      r_xfer_cnt;

    // in_ready depends only on pipe occupancy and out_ready, never on in_valid
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_in_xfer = in_valid && w_s1_load;
    assign w_s2_adv  = w_s2_load && r_s1_valid;

    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign out_tag   = r_s2_tag;
    assign xfer_cnt  = r_xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_op    <= 2'b00;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
            r_xfer_cnt <= 16'd0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_xfer) begin
                r_s1_op  <= in_op;
                r_s1_tag <= in_tag;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_adv) begin
                r_s2_tag <= r_s1_tag;
            end
            if (r_s2_valid && out_ready) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH:0]   w_raw;
        logic [WIDTH:0]   r_raw;
        logic             r_bz;
        logic [WIDTH-1:0] w_res;
        logic [WIDTH-1:0] r_res;

        assign w_a = in_a[gi*WIDTH +: WIDTH];
        assign w_b = in_b[gi*WIDTH +: WIDTH];

        always_comb begin
            w_raw = {1'b0, w_a};
            case (in_op)
                c_OP_ADD: w_raw = {1'b0, w_a} + {1'b0, w_b};
                c_OP_SUB: w_raw = {1'b0, w_a} - {1'b0, w_b};
                c_OP_NEG: w_raw = c_MOD - {1'b0, w_b};
                default:  w_raw = {1'b0, w_a};
            endcase
        end

`ifdef MOD_RANGE_CHECK_EN
        logic w_err;
        logic r_s1_err;
        logic r_s2_err;

        always_comb begin
            w_err = (w_a >= c_MOD_W) || (w_b >= c_MOD_W);
            case (in_op)
                c_OP_NEG: w_err = (w_b >= c_MOD_W);
                c_OP_ADD,
                c_OP_SUB: w_err = (w_a >= c_MOD_W) || (w_b >= c_MOD_W);
                default:  w_err = (w_a >= c_MOD_W);
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1_err <= 1'b0;
                r_s2_err <= 1'b0;
            end else begin
                if (w_in_xfer) begin
                    r_s1_err <= w_err;
                end
                if (w_s2_adv) begin
                    r_s2_err <= r_s1_err;
                end
            end
        end

        assign out_err[gi] = r_s2_err;
`endif

        // Low WIDTH bits of the WIDTH+1 sums suffice for the corrected result
        always_comb begin
            w_res = r_raw[WIDTH-1:0];
            case (r_s1_op)
                c_OP_ADD: if (r_raw >= c_MOD) w_res = r_raw[WIDTH-1:0] - c_MOD_W;
                c_OP_SUB: if (r_raw[WIDTH])   w_res = r_raw[WIDTH-1:0] + c_MOD_W;
                c_OP_NEG: if (r_bz)           w_res = '0;
                default:  w_res = r_raw[WIDTH-1:0];
            endcase
`ifdef MOD_RANGE_CHECK_EN
            if (r_s1_err) begin
                w_res = '0;
            end
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_raw <= '0;
                r_bz  <= 1'b0;
                r_res <= '0;
            end else begin
                if (w_in_xfer) begin
                    r_raw <= w_raw;
                    r_bz  <= (w_b == '0);
                end
                if (w_s2_adv) begin
                    r_res <= w_res;
                end
            end
        end

        assign out_res[gi*WIDTH +: WIDTH] = r_res;
    end

`ifndef MOD_RANGE_CHECK_EN
    assign out_err = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_addsub_pipe
// Description : Self-checking bench for mod_addsub_pipe (vector table,
//               handshake sequences, randomized stream vs. reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_addsub_pipe;

    localparam int              WIDTH = 32;
    localparam longint unsigned MOD   = 998244353;
    localparam int              LANES = 4;
    localparam int              TAG_W = 4;
    localparam int              VW    = LANES*WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [VW-1:0]     in_a;
    logic [VW-1:0]     in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_res;
    logic [TAG_W-1:0]  out_tag;
    logic [LANES-1:0]  out_err;
    logic [15:0]       xfer_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [VW-1:0]    res;
        logic [TAG_W-1:0] tag;
        logic [LANES-1:0] err;
    } exp_t;

    typedef struct {
        logic [1:0]       op;
        logic [VW-1:0]    a;
        logic [VW-1:0]    b;
        logic [TAG_W-1:0] tag;
        logic [VW-1:0]    res;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[4];

    mod_addsub_pipe #(
        .WIDTH(WIDTH), .MOD(MOD), .LANES(LANES), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_err(out_err),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain modular arithmetic on integers
    function automatic exp_t model(input logic [1:0] op, input logic [VW-1:0] a,
                                   input logic [VW-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        longint unsigned x, y, r;
        e.tag = tag;
        e.res = '0;
        e.err = '0;
        for (int i = 0; i < LANES; i++) begin
            x = longint'(a[i*WIDTH +: WIDTH]);
            y = longint'(b[i*WIDTH +: WIDTH]);
            case (op)
                2'd0:    r = (x + y) % MOD;
                2'd1:    r = (x + MOD - y) % MOD;
                2'd2:    r = (MOD - y) % MOD;
                default: r = x;
            endcase
`ifdef MOD_RANGE_CHECK_EN
            begin
                bit bad;
                bad = (op == 2'd2) ? (y >= MOD) : (op == 2'd3) ? (x >= MOD) : (x >= MOD || y >= MOD);
                if (bad) r = 0;
                e.err[i] = bad;
            end
`endif
            e.res[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return WIDTH'(MOD - 1);
            default: return WIDTH'($urandom_range(0, 32'(MOD - 1)));
        endcase
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = rnd_val();
        return v;
    endfunction

    // Scoreboard: model on accept, compare in order on each output transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got tag %0h res %0h expected no output", out_tag, out_res);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_res", out_res, e.res);
                    chk("sb_tag", VW'(out_tag), VW'(e.tag));
                    chk("sb_err", VW'(out_err), VW'(e.err));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
        end
    end

    task automatic drive(input logic [1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        bit acc;

        tbl[0] = '{2'd0, {32'd100, 32'd998244352, 32'd5, 32'd998244352},
                         {32'd200, 32'd998244352, 32'd7, 32'd1}, 4'd5,
                         {32'd300, 32'd998244351, 32'd12, 32'd0}};
        tbl[1] = '{2'd1, {32'd998244352, 32'd5, 32'd10, 32'd0},
                         {32'd0, 32'd5, 32'd3, 32'd1}, 4'd9,
                         {32'd998244352, 32'd0, 32'd7, 32'd998244352}};
        tbl[2] = '{2'd2, {32'd77, 32'd77, 32'd77, 32'd77},
                         {32'd12345, 32'd998244352, 32'd1, 32'd0}, 4'd3,
                         {32'd998232008, 32'd1, 32'd998244352, 32'd0}};
        tbl[3] = '{2'd3, {32'd1, 32'd2, 32'd3, 32'd998244352},
                         {32'd9, 32'd9, 32'd9, 32'd9}, 4'd15,
                         {32'd1, 32'd2, 32'd3, 32'd998244352}};

        rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", VW'(out_valid), '0);
        chk("rst_out_res", out_res, '0);
        chk("rst_out_tag", VW'(out_tag), '0);
        chk("rst_out_err", VW'(out_err), '0);
        chk("rst_xfer_cnt", VW'(xfer_cnt), '0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rst_in_ready", VW'(in_ready), VW'(1));

        // Directed vectors with exact two-cycle latency
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_lat1_valid", i), VW'(out_valid), '0);
            step();
            chk($sformatf("tbl%0d_valid", i), VW'(out_valid), VW'(1));
            chk($sformatf("tbl%0d_res", i), out_res, tbl[i].res);
            chk($sformatf("tbl%0d_tag", i), VW'(out_tag), VW'(tbl[i].tag));
        end
        step();

        // Backpressure: two accepts, third held until downstream ready
        out_ready = 1'b0;
        drive(2'd3, {4{32'd1}}, '0, 4'd1);
        chk("bp_rdy_empty", VW'(in_ready), VW'(1));
        step();
        chk("bp_rdy_one", VW'(in_ready), VW'(1));
        drive(2'd3, {4{32'd2}}, '0, 4'd2);
        step();
        chk("bp_rdy_full", VW'(in_ready), '0);
        drive(2'd3, {4{32'd3}}, '0, 4'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall_rdy", VW'(in_ready), '0);
            chk("bp_stall_tag", VW'(out_tag), VW'(1));
            chk("bp_stall_res", out_res, {4{32'd1}});
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_tag2", VW'(out_tag), VW'(2));
        step();
        chk("bp_tag3", VW'(out_tag), VW'(3));
        chk("bp_res3", out_res, {4{32'd3}});
        step();
        chk("bp_drained", VW'(out_valid), '0);

        // Reset with two vectors in flight
        out_ready = 1'b0;
        drive(2'd0, {4{32'd6}}, {4{32'd1}}, 4'd6);
        step();
        drive(2'd0, {4{32'd7}}, {4{32'd1}}, 4'd7);
        step();
        in_valid = 1'b0;
        chk("mid_pre_valid", VW'(out_valid), VW'(1));
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", VW'(out_valid), '0);
        chk("mid_rst_xfer", VW'(xfer_cnt), '0);
        chk("mid_rst_res", out_res, '0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("mid_no_stale", VW'(out_valid), '0);

        // Randomized stream with random valid/ready
        sent = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (sent < 100 && !in_valid && $urandom_range(0, 3) != 0)
                drive(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), 4'($urandom_range(0, 15)));
            out_ready = (sent >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (sent >= 100 && exp_q.size() == 0 && !out_valid) break;
        end
        in_valid = 1'b0;
        chk("stream_sent", VW'(sent), VW'(100));
        chk("stream_xfer_cnt", VW'(xfer_cnt), VW'(100));
        chk("stream_q_empty", VW'(exp_q.size()), '0);

`ifdef MOD_RANGE_CHECK_EN
        out_ready = 1'b1;
        drive(2'd0, {32'd0, 32'd998244353, 32'd3, 32'd998244352},
                    {32'd1, 32'd1, 32'd4, 32'd1}, 4'd11);
        step();
        in_valid = 1'b0;
        step();
        chk("rc_err", VW'(out_err), VW'(4'b0100));
        chk("rc_res", out_res, {32'd1, 32'd0, 32'd7, 32'd0});
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
Multi-lane, pipelined modular add/subtract/negate unit over a fixed modulus MOD. It generalises the combinational modular subtractor to LANES parallel lanes with a selectable operation, a 2-stage registered datapath and valid/ready flow control. It sits between the operand scheduler and the NTT butterfly or accumulator stages, and accepts one vector of LANES operand pairs per cycle.

Parameters:
WIDTH, 32, operand/result bit width per lane; MOD < 2^WIDTH required
MOD, 998244353, modulus; operands are nominally in [0, MOD-1]
LANES, 4, number of independent parallel lanes
TAG_W, 4, width of the user tag carried alongside each transaction

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  unit can accept the input vector this cycle
in_op  in  2  operation: 00 a+b, 01 a-b, 10 -b (MOD-b), 11 pass a
in_a  in  LANES*WIDTH  operand a, lane i at bits [i*WIDTH +: WIDTH]
in_b  in  LANES*WIDTH  operand b, same packing as in_a
in_tag  in  TAG_W  user tag, returned unchanged with the result
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts the result this cycle
out_res  out  LANES*WIDTH  results, same packing as the inputs
out_tag  out  TAG_W  tag of the current result
out_err  out  LANES  per-lane range error (see Optional Feature)
xfer_cnt  out  16  count of completed output transfers

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, out_res=0, out_tag=0, out_err=0, xfer_cnt=0. Reset mid-operation discards all in-flight vectors; none are emitted after reset releases.
- Pipeline: stage S1 registers the raw result; stage S2 registers the corrected result, which drives the out_* ports directly.
- Latency: a vector accepted in cycle N appears with out_valid=1 in cycle N+2 when out_ready is held high.
- Throughput: 1 vector/cycle with no backpressure.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load, a combinational function of the pipe state and out_ready only, never of in_valid.
  - While stalled, out_res, out_tag and out_err hold stable.
  - Up to 2 vectors are buffered; order is preserved, and no vector is dropped or duplicated.
- S1 arithmetic, per lane, with WIDTH+1 bit intermediates:
  - add: raw = a + b.
  - sub: raw = {1'b0,a} - {1'b0,b}; the borrow is kept in bit WIDTH.
  - neg: raw = MOD - b.
  - pass: raw = a.
- S2 correction:
  - add: res = (raw >= MOD) ? raw - MOD : raw.
  - sub: res = borrow ? raw + MOD (truncated to WIDTH) : raw.
  - neg: res = (b == 0) ? 0 : raw. The b==0 flag is piped from S1.
  - pass: res = raw.
- Results are always in [0, MOD-1] for in-range operands. No overflow occurs at any intermediate, because WIDTH+1 bits are used.
- Simultaneous input and output transfer with both stages full: allowed. Both stages advance in the same cycle.
- xfer_cnt increments on each output transfer and wraps from 0xFFFF to 0.

Optional Feature:
- Macro: MOD_RANGE_CHECK_EN.
- Defined:
  - S1 flags per lane err = (a >= MOD) || (b >= MOD). For op 10 only b is checked; for op 11 only a is checked.
  - The flag is piped with the data and appears on out_err aligned with out_res.
  - An erroring lane outputs res = 0.
- Undefined:
  - out_err is tied to 0.
  - No comparison logic is generated.
  - Out-of-range operands give unspecified but deterministic results.

Test Plan:
- Add wrap: op=00, lane0 a=998244352 b=1, lane1 a=5 b=7, out_ready=1 -> after 2 cycles, lane0=0, lane1=12, out_tag equals in_tag.
- Sub borrow: op=01, a=0 b=1 and a=10 b=3 -> 998244352 and 7. Neg: op=10, b=0 -> 0; b=1 -> 998244352.
- Backpressure: push 3 back-to-back vectors tagged 1,2,3 with out_ready=0 -> in_ready drops to 0 after 2 accepts. Tag 3 is held off until out_ready=1, then outputs appear in order 1,2,3 and out_res stays stable while stalled.
- Streaming: 100 random in-range vectors, random in_valid/out_ready -> every result matches the (a op b) mod MOD golden model, in order, and xfer_cnt=100.
- Reset mid-flight: assert rst with 2 vectors in the pipe -> out_valid=0 and xfer_cnt=0 immediately (asynchronously). After release, no stale vectors are emitted.
- With MOD_RANGE_CHECK_EN: op=00, a=998244353 on lane2 -> out_err=4'b0100, lane2 res=0, other lanes correct.
